fp16_norm_round: RTL and testbench

FP16_NORM_ROUND -- requirements
Module: fp16_norm_round

---
 rtl/fp16_pkg.sv | 22 ++
 rtl/fp16_round_rne.sv | 12 +
 rtl/fp16_norm_round.sv | 110 +++++++++++
 tb/tb_fp16_norm_round.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// fp16_pkg: shared constants, operand classes and the stage-1 record for the FP16 multiplier back end.
package fp16_pkg;
    localparam int BIAS   = 15;
    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int PROD_W = 22;
    localparam int E_W    = EXP_W + 2;
    localparam logic [15:0] QNAN = 16'h7E00;
    localparam int F_INV = 3;
    localparam int F_OVF = 2;
    localparam int F_UNF = 1;
    localparam int F_INX = 0;
    typedef enum logic [2:0] {C_NORM, C_ZERO, C_INF, C_NAN, C_INVALID} cls_t;
    typedef struct packed {
        logic                   sign;
        cls_t                   cls;
        logic signed [E_W-1:0]  e;
        logic [FRAC_W-1:0]      frac;
        logic                   guard;
        logic                   sticky;
    } s1_t;
endpackage

// File: rtl/fp16_round_rne.sv
// fp16_round_rne: round-to-nearest-even increment of a normalised fraction, reporting carry-out.
module fp16_round_rne
    import fp16_pkg::*;
(
    input  logic [FRAC_W-1:0] frac,
    input  logic              guard,
    input  logic              sticky,
    output logic [FRAC_W-1:0] frac_r,
    output logic              carry
);
    assign {carry, frac_r} = {1'b0, frac} + {{FRAC_W{1'b0}}, guard & (sticky | frac[0])};
endmodule

// File: rtl/fp16_norm_round.sv
// fp16_norm_round: two-stage normalise / round / exception back end of an FP16 multiplier.
module fp16_norm_round
    import fp16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       op_a,
    input  logic [15:0]       op_b,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       result,
    output logic [3:0]        flags
);
    logic s1_valid, s2_valid, s1_advance;
    s1_t s1, s1_d;
    logic [EXP_W-1:0] ea, eb;
    logic [FRAC_W-1:0] fa, fb, frac_r;
    logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, hi, carry, ovf, unf;
    logic signed [E_W-1:0] e2;
    logic [15:0] res_d;
    logic [3:0] flg_d;

    assign s1_advance = !s2_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign out_valid  = s2_valid;

    assign {ea, fa} = op_a[14:0];
    assign {eb, fb} = op_b[14:0];
    assign zero_a = ea == '0;
    assign zero_b = eb == '0;
    assign inf_a  = &ea && fa == '0;
    assign inf_b  = &eb && fb == '0;
    assign nan_a  = &ea && |fa;
    assign nan_b  = &eb && |fb;
    assign hi     = product[PROD_W-1];

    // Stage 1: classify operands, sum exponents and normalise the mantissa product.
    always_comb begin
        s1_d.sign   = op_a[15] ^ op_b[15];
        s1_d.cls    = (nan_a || nan_b) ? C_NAN :
                      ((inf_a && zero_b) || (inf_b && zero_a)) ? C_INVALID :
                      (inf_a || inf_b) ? C_INF :
                      (zero_a || zero_b) ? C_ZERO : C_NORM;
        s1_d.e      = {2'b0, ea} + {2'b0, eb} + {{(E_W-1){1'b0}}, hi} - E_W'(BIAS);
        s1_d.frac   = hi ? product[20:11] : product[19:10];
        s1_d.guard  = hi ? product[10] : product[9];
        s1_d.sticky = hi ? |product[9:0] : |product[8:0];
    end

    fp16_round_rne u_rnd (
        .frac   (s1.frac),
        .guard  (s1.guard),
        .sticky (s1.sticky),
        .frac_r (frac_r),
        .carry  (carry)
    );

    assign e2  = s1.e + {{(E_W-1){1'b0}}, carry};
    assign ovf = e2 >= $signed(E_W'(2**EXP_W - 1));
    assign unf = e2 <= $signed(E_W'(0));

    // Stage 2: resolve specials, overflow and underflow around the rounded value.
    always_comb begin
        res_d = {s1.sign, e2[EXP_W-1:0], frac_r};
        flg_d = '0;
        if (s1.cls == C_NAN) res_d = QNAN;
        else if (s1.cls == C_INVALID) begin
            res_d = QNAN;
            flg_d[F_INV] = 1'b1;
        end
        else if (s1.cls == C_INF) res_d = {s1.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else if (s1.cls == C_ZERO) res_d = {s1.sign, 15'h0};
        else if (ovf) begin
            res_d = {s1.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flg_d[F_OVF] = 1'b1;
            flg_d[F_INX] = 1'b1;
        end
        else if (unf) begin
            res_d = {s1.sign, 15'h0};
            flg_d[F_UNF] = 1'b1;
            flg_d[F_INX] = 1'b1;
        end
        else flg_d[F_INX] = s1.guard | s1.sticky;
    end

    // Pipeline occupancy and the output register; results hold while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            result   <= '0;
            flags    <= '0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (s1_advance) s2_valid <= s1_valid;
            if (s1_advance && s1_valid) begin
                result <= res_d;
                flags  <= flg_d;
            end
        end
    end

    // Stage-1 datapath register, loaded only on an accepted beat.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) s1 <= s1_d;
    end
endmodule

// File: tb/tb_fp16_norm_round.sv
// tb_fp16_norm_round: directed and randomised checks of the FP16 normalise/round back end.
module tb_fp16_norm_round;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] op_a, op_b, result;
    logic [21:0] product;
    logic [3:0] flags;
    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];

    fp16_norm_round dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Arithmetic reference: exact quotient/remainder rounding of the real product value.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic [21:0] p);
        int ea, eb, fa, fb, sh, e, m, rem, half;
        logic s;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        fa = int'(a[9:0]);
        fb = int'(b[9:0]);
        s = a[15] ^ b[15];
        if ((ea == 31 && fa != 0) || (eb == 31 && fb != 0)) return {4'b0000, 16'h7E00};
        if ((ea == 31 && eb == 0) || (eb == 31 && ea == 0)) return {4'b1000, 16'h7E00};
        if (ea == 31 || eb == 31) return {4'b0000, s, 5'h1F, 10'h0};
        if (ea == 0 || eb == 0) return {4'b0000, s, 15'h0};
        sh = (int'(p) >= (1 << 21)) ? 11 : 10;
        e = ea + eb - 15 + (sh - 10);
        m = int'(p) >> sh;
        rem = int'(p) % (1 << sh);
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && m % 2 == 1)) m = m + 1;
        if (m == 2048) begin
            m = 1024;
            e = e + 1;
        end
        if (e >= 31) return {4'b0101, s, 5'h1F, 10'h0};
        if (e <= 0) return {4'b0011, s, 15'h0};
        return {3'b000, rem != 0, s, 5'(e), 10'(m)};
    endfunction

    task automatic rnd_beat(output logic [15:0] a, output logic [15:0] b, output logic [21:0] p);
        int sa, sb;
        a = 16'($urandom);
        b = 16'($urandom);
        sa = $urandom_range(0, 7);
        sb = $urandom_range(0, 7);
        if (sa == 0) a[14:10] = 5'h1F; else if (sa == 1) a[14:10] = 5'h00; else if (sa > 3) a[14:10] = 5'($urandom_range(8, 22));
        if (sb == 0) b[14:10] = 5'h1F; else if (sb == 1) b[14:10] = 5'h00; else if (sb > 3) b[14:10] = 5'($urandom_range(8, 22));
        if (a[14:10] == 0 || b[14:10] == 0) p = 22'($urandom);
        else p = 22'((1024 + int'(a[9:0])) * (1024 + int'(b[9:0])));
    endtask

    task automatic cyc(input bit iv, input logic [15:0] a, input logic [15:0] b, input logic [21:0] p,
                       input bit ordy, output bit acc);
        logic [19:0] e;
        in_valid = iv;
        op_a = a;
        op_b = b;
        product = p;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            chk("out_has_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("stream_result", result, e[15:0]);
                chk("stream_flags", flags, e[19:16]);
            end
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(model(a, b, p));
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [21:0] p,
                            input logic [15:0] er, input logic [3:0] ef);
        chk({tag, "_idle_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        product = p;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        @(posedge clk);
        #1;
        chk({tag, "_lat2"}, out_valid, 1);
        chk({tag, "_result"}, result, er);
        chk({tag, "_flags"}, flags, ef);
        @(posedge clk);
        #1;
        chk({tag, "_done"}, out_valid, 0);
    endtask

    initial begin
        logic [15:0] a, b, r0;
        logic [21:0] p;
        logic [3:0] f0;
        bit acc;
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        product = '0;
        out_ready = 1'b1;
        #3;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("reset_result", result, 0);
        chk("reset_flags", flags, 0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        send_one("one_x_one", 16'h3C00, 16'h3C00, 22'h100000, 16'h3C00, 4'b0000);
        send_one("1p5_x_1p5", 16'h3E00, 16'h3E00, 22'h240000, 16'h4080, 4'b0000);
        send_one("max_x_max", 16'h7BFF, 16'h7BFF, 22'h3FF001, 16'h7C00, 4'b0101);
        send_one("inf_x_zero", 16'h7C00, 16'h0000, 22'h000000, 16'h7E00, 4'b1000);
        send_one("nan_x_one", 16'h7E00, 16'h3C00, 22'h100000, 16'h7E00, 4'b0000);
        send_one("underflow", 16'h8400, 16'h0400, 22'h100000, 16'h8000, 4'b0011);
        send_one("ninf_x_one", 16'hFC00, 16'h3C00, 22'h100000, 16'hFC00, 4'b0000);
        send_one("zero_x_neg", 16'h0000, 16'hBC00, 22'h3FFFFF, 16'h8000, 4'b0000);
        send_one("rne_tie_up", 16'h3C01, 16'h3E00, 22'h180600, 16'h3E02, 4'b0001);

        for (int i = 0; i < 400; i++) begin
            rnd_beat(a, b, p);
            cyc($urandom_range(0, 3) != 0, a, b, p, $urandom_range(0, 3) != 0, acc);
        end
        for (int i = 0; i < 6; i++) cyc(1'b0, a, b, p, 1'b1, acc);
        chk("random_drained", exp_q.size(), 0);

        n = 0;
        rnd_beat(a, b, p);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, a, b, p, 1'b0, acc);
            if (acc) begin
                n++;
                rnd_beat(a, b, p);
            end
        end
        chk("stall_accepted", n, 2);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        r0 = result;
        f0 = flags;
        cyc(1'b0, a, b, p, 1'b0, acc);
        chk("hold_result", result, r0);
        chk("hold_flags", flags, f0);
        for (int i = 0; i < 4; i++) cyc(1'b0, a, b, p, 1'b1, acc);
        chk("stall_drained", exp_q.size(), 0);

        for (int i = 0; i < 3; i++) begin
            rnd_beat(a, b, p);
            cyc(1'b1, a, b, p, 1'b0, acc);
        end
        chk("inflight_before_reset", exp_q.size(), 2);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset_out_valid", out_valid, 0);
        chk("async_reset_in_ready", in_ready, 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("release_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, a, b, p, 1'b1, acc);
            chk("no_stale_output", out_valid, 0);
        end
        send_one("after_reset", 16'h3C00, 16'h3C00, 22'h100000, 16'h3C00, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
